// File: rtl/wgrid_pkg.sv
// Shared types and helpers for the 2-D grid weight coder.
// Packet framing constants and the serializer state encoding live here.
package wgrid_pkg;

    localparam logic [15:0] HDR_DEF = 16'h5566;
    localparam int HDR_BYTES = 3;

    typedef enum logic {IDLE, SEND} ser_state_t;

    function automatic int pkt_len(input int sum_w);
        return HDR_BYTES + sum_w / 8;
    endfunction

    function automatic logic [7:0] pack_idx(input logic [3:0] row,
                                            input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/wgrid_fifo.sv
// Synchronous FIFO for finished block entries.
// A write while full is accepted only if a read frees a slot in the same cycle.
module wgrid_fifo
    import wgrid_pkg::*;
#(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            if (rd_ok) rptr <= rptr + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wgrid_coder.sv
// Grid block summer: accumulates din per BLK_W x BLK_H block and
// streams one header/index/sum packet per finished block.
module wgrid_coder
    import wgrid_pkg::*;
#(
    parameter int          PIX_W        = 8,
    parameter int          BLK_W        = 10,
    parameter int          BLK_H        = 3,
    parameter int          BLKS_PER_ROW = 4,
    parameter int          SUM_W        = 16,
    parameter logic [15:0] HDR          = HDR_DEF,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                          pclk,
    input  logic                          rst,
    input  logic                          vsync,
    input  logic                          href,
    input  logic [PIX_W-1:0]              din,
    input  logic                          dout_ready,
    output logic [7:0]                    dout,
    output logic                          dout_valid,
    output logic                          dout_last,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CIW = $clog2(BLK_W + 1);
    localparam int LIW = $clog2(BLK_H + 1);
    localparam int BCW = 5;
    localparam int EW  = 8 + SUM_W;
    localparam int PL  = pkt_len(SUM_W);
    localparam int SW  = PL * 8;

    logic [CIW-1:0]   col_idx;
    logic [BCW-1:0]   blk_col;
    logic [LIW-1:0]   line_in_blk;
    logic [7:0]       blk_row;
    logic [SUM_W-1:0] acc [BLKS_PER_ROW];
    logic             href_q;
    logic             vsync_q;
    logic             wr_q;
    logic [EW-1:0]    wr_data;

    logic             in_act;
    logic             last_pix;
    logic             last_line;
    logic [SUM_W-1:0] acc_cur;
    logic [SUM_W:0]   acc_ext;
    logic [SUM_W-1:0] acc_sum;

    logic             full;
    logic             empty;
    logic             rd_en;
    logic             drop;
    logic [EW-1:0]    rd_data;

    ser_state_t       state;
    logic [SW-1:0]    shreg;
    logic [3:0]       bcnt;

    assign in_act    = (blk_col < BCW'(BLKS_PER_ROW));
    assign last_pix  = (col_idx == CIW'(BLK_W - 1));
    assign last_line = (line_in_blk == LIW'(BLK_H - 1));
    assign rd_en     = (state == IDLE) && !empty;
    assign drop      = wr_q && full && !rd_en;
    assign dout      = shreg[SW-1 -: 8];

    // Mux rather than index so a past-active-width blk_col never reads out of range.
    always_comb begin
        acc_cur = '0;
        for (int i = 0; i < BLKS_PER_ROW; i++) begin
            if (BCW'(i) == blk_col) acc_cur = acc[i];
        end
        acc_ext = {1'b0, acc_cur} + (SUM_W+1)'(din);
        acc_sum = acc_ext[SUM_W] ? '1 : acc_ext[SUM_W-1:0];
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            col_idx     <= '0;
            blk_col     <= '0;
            line_in_blk <= '0;
            blk_row     <= '0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            wr_q        <= 1'b0;
            wr_data     <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < BLKS_PER_ROW; i++) acc[i] <= '0;
        end else begin
            href_q  <= href;
            vsync_q <= vsync;
            wr_q    <= 1'b0;
            if (vsync && !vsync_q) begin
                col_idx     <= '0;
                blk_col     <= '0;
                line_in_blk <= '0;
                blk_row     <= '0;
                overflow    <= 1'b0;
                for (int i = 0; i < BLKS_PER_ROW; i++) acc[i] <= '0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (href) begin
                    if (in_act) begin
                        for (int i = 0; i < BLKS_PER_ROW; i++) begin
                            if (BCW'(i) == blk_col)
                                acc[i] <= (last_pix && last_line) ? '0 : acc_sum;
                        end
                        if (last_pix) begin
                            col_idx <= '0;
                            blk_col <= blk_col + BCW'(1);
                            if (last_line) begin
                                wr_q    <= 1'b1;
                                wr_data <= {pack_idx(blk_row[3:0], blk_col[3:0]), acc_sum};
                            end
                        end else begin
                            col_idx <= col_idx + CIW'(1);
                        end
                    end
                end else begin
                    col_idx <= '0;
                    blk_col <= '0;
                    if (href_q) begin
                        if (last_line) begin
                            line_in_blk <= '0;
                            blk_row     <= blk_row + 8'd1;
                        end else begin
                            line_in_blk <= line_in_blk + LIW'(1);
                        end
                    end
                end
            end
        end
    end

    wgrid_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pclk),
        .rst     (rst),
        .wr_en   (wr_q),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bcnt       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg      <= {HDR, rd_data};
                        bcnt       <= '0;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b0;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (dout_ready) begin
                        if (dout_last) begin
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            shreg     <= shreg << 8;
                            bcnt      <= bcnt + 4'd1;
                            dout_last <= (bcnt == 4'(PL - 2));
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wgrid_coder.sv
// Directed bench for wgrid_coder: default build plus an 8-bit-sum build
// sharing the capture inputs.
module tb_wgrid_coder;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] din = 8'd0;
    logic       dout_ready = 1'b1;
    logic       rdy8 = 1'b1;

    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;
    logic       overflow;
    logic [3:0] fifo_level;
    logic [7:0] d8;
    logic       v8;
    logic       l8;
    logic       ov8;
    logic [3:0] lv8;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q16 [$];
    logic [8:0] q8 [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = 8'd0;
    int         stalls = 0;
    int         max_level = 0;
    bit         tog = 1'b0;

    always #5 pclk = ~pclk;

    wgrid_coder dut (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .din        (din),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    wgrid_coder #(.SUM_W(8)) dut8 (
        .pclk       (pclk),
        .rst        (rst),
        .vsync      (vsync),
        .href       (href),
        .din        (din),
        .dout_ready (rdy8),
        .dout       (d8),
        .dout_valid (v8),
        .dout_last  (l8),
        .overflow   (ov8),
        .fifo_level (lv8)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle monitor: records accepted bytes and checks stall stability.
    always @(negedge pclk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {dout_valid, dout}, {1'b1, prev_dout});
            if (dout_valid && dout_ready) q16.push_back({dout_last, dout});
            if (dout_valid && !dout_ready) stalls++;
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (v8) q8.push_back({l8, d8});
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    always @(posedge pclk) begin
        if (tog) begin
            #2 dout_ready = ~dout_ready;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic frame();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic send_line(input int n, input logic [7:0] val);
        href = 1'b1;
        din  = val;
        repeat (n) tick();
        href = 1'b0;
        din  = 8'd0;
        repeat (4) tick();
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (fifo_level == 0 && !dout_valid && lv8 == 0 && !v8) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1);
        repeat (3) tick();
    endtask

    task automatic pkts16(input string tag, input int n, input logic [15:0] sum);
        logic [8:0]  b;
        logic [39:0] data;
        logic [4:0]  lst;
        chk({tag, "_len"}, q16.size(), 5 * n);
        if (q16.size() == 5 * n) begin
            for (int k = 0; k < n; k++) begin
                data = '0;
                lst  = '0;
                for (int j = 0; j < 5; j++) begin
                    b    = q16.pop_front();
                    data = {data[31:0], b[7:0]};
                    lst  = {lst[3:0], b[8]};
                end
                chk(tag, data, {16'h5566, 4'(k / 4), 4'(k % 4), sum});
                chk({tag, "_last"}, lst, 5'b00001);
            end
        end
        q16.delete();
    endtask

    task automatic pkts8(input string tag, input int n, input logic [7:0] sum);
        logic [8:0]  b;
        logic [31:0] data;
        logic [3:0]  lst;
        chk({tag, "_len"}, q8.size(), 4 * n);
        if (q8.size() == 4 * n) begin
            for (int k = 0; k < n; k++) begin
                data = '0;
                lst  = '0;
                for (int j = 0; j < 4; j++) begin
                    b    = q8.pop_front();
                    data = {data[23:0], b[7:0]};
                    lst  = {lst[2:0], b[8]};
                end
                chk(tag, data, {16'h5566, 4'(k / 4), 4'(k % 4), sum});
                chk({tag, "_last"}, lst, 4'b0001);
            end
        end
        q8.delete();
    endtask

    initial begin
        logic got;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        tick();

        frame();
        repeat (3) send_line(40, 8'd1);
        drain();
        pkts16("ones", 4, 16'h001E);
        pkts8("ones8", 4, 8'h1E);

        frame();
        repeat (3) send_line(50, 8'd1);
        drain();
        pkts16("wide", 4, 16'h001E);
        pkts8("wide8", 4, 8'h1E);

        frame();
        repeat (3) send_line(40, 8'hFF);
        drain();
        pkts16("sat", 4, 16'h1DE2);
        pkts8("sat8", 4, 8'hFF);

        frame();
        stalls = 0;
        tog = 1'b1;
        repeat (3) send_line(40, 8'd2);
        drain();
        tog = 1'b0;
        tick();
        dout_ready = 1'b1;
        tick();
        chk("stalls_seen", stalls > 0, 1);
        pkts16("toggle", 4, 16'h003C);
        pkts8("toggle8", 4, 8'h3C);

        frame();
        dout_ready = 1'b0;
        max_level = 0;
        q8.delete();
        repeat (9) send_line(40, 8'd1);
        chk("ovf_set", overflow, 1);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_peak", max_level, 8);
        chk("ovf8_clear", ov8, 0);
        dout_ready = 1'b1;
        drain();
        chk("ovf_sticky", overflow, 1);
        pkts16("ovf", 9, 16'h001E);
        chk("ovf8_len", q8.size(), 48);
        q8.delete();
        frame();
        chk("ovf_vsync_clr", overflow, 0);

        dout_ready = 1'b0;
        repeat (3) send_line(40, 8'd1);
        q16.delete();
        q8.delete();
        dout_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (q16.size() >= 2) begin
                got = 1'b1;
                break;
            end
        end
        chk("rst_wait", got, 1);
        chk("pre_rst_level", fifo_level, 3);
        rst = 1'b1;
        dout_ready = 1'b0;
        tick();
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_nbytes", q16.size(), 2);
        if (q16.size() == 2)
            chk("mid_rst_bytes", {q16[0][7:0], q16[1][7:0]}, 16'h5566);
        rst = 1'b0;
        dout_ready = 1'b1;
        q16.delete();
        q8.delete();
        tick();
        frame();
        repeat (3) send_line(40, 8'd3);
        drain();
        pkts16("post_rst", 4, 16'h005A);
        pkts8("post_rst8", 4, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
